agu_alu_bus_datapath: RTL and testbench
=======================================

Name: agu_alu_bus_datapath

Overview:
- Execution/memory datapath slice of the 32-bit core.
- Combinational address generation unit (AGU): base + sign-extended immediate, or base + register.
- Registered ALU with C/Z/N/V flag outputs; flags feed an external status register.
- Combinational bus interface: selects the fetch or data address, generates byte strobes and lane steering, and flags misaligned accesses.

Parameters:
- none (32-bit datapath fixed)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  synchronous, active-high
- memory_access_cycle  in  1  1 = data access via AGU; 0 = instruction fetch from pc
- pc  in  32  program counter (fetch address)
- base_address  in  32  AGU base register value
- immediate_mode  in  1  1 = AGU offset is the immediate; 0 = register_data
- immediate  in  16  signed AGU offset
- register_data  in  32  AGU register offset
- memory_read, memory_write  in  1 each  data-cycle direction
- memory_cycle_width  in  2  data-cycle width: 00 byte, 01 word, 10 long, 11 invalid
- store_data  in  32  store value, right-justified
- agu_result  out  32  computed effective address
- alu_op  in  5  ALU operation
- alu_reg2, alu_reg3  in  32 each  ALU operands A and B
- carry_in  in  1  carry from the status register
- alu_result  out  32  registered ALU result
- carry_out, zero_out, neg_out, over_out  out  1 each  registered flags
- address  out  30  bus longword address [31:2]
- data_in  in  32  bus read data
- data_out  out  32  bus write data
- data_strobes  out  4  byte enables; [3] = byte offset 0 (big-endian)
- read, write  out  1 each  bus strobes
- bus_error  out  1  misaligned or invalid-width access
- cpu_data_in  out  32  read data, right-justified and zero-extended

Behaviour:

AGU (combinational):
- agu_result = base_address + (immediate_mode ? sign-extended immediate : register_data), modulo 2^32.

Bus address and width selection:
- memory_access_cycle=0 (fetch):
  - effective address = pc
  - read = 1, write = 0
  - width = long
  - data_out = 0
- memory_access_cycle=1 (data):
  - effective address = agu_result
  - read/write = memory_read/memory_write
  - width = memory_cycle_width

Bus interface (combinational), with addr = effective address:
- address = addr[31:2].
- long:
  - strobes 1111
  - data_out = store_data
  - cpu_data_in = data_in
- word, addr[1]=0:
  - strobes 1100
  - cpu_data_in = {16'b0, data_in[31:16]}
- word, addr[1]=1:
  - strobes 0011
  - cpu_data_in = {16'b0, data_in[15:0]}
  - word data_out = {store_data[15:0], store_data[15:0]}
- byte, offset 0..3:
  - strobes 1000 / 0100 / 0010 / 0001
  - cpu_data_in = {24'b0, selected lane}; offset 0 = data_in[31:24]
  - data_out = store byte replicated on all four lanes
- bus_error = (read|write) and (long with addr[1:0]≠0, or word with addr[0]=1, or width 11).
- When bus_error=1: strobes 0000, read = write = 0.
- When neither read nor write: strobes 0000, bus_error 0.

ALU (registered, latency 1):
- All outputs update on every rising edge from the current inputs.
- reset → alu_result = 0, all flags 0.
- Op encodings:
  - 0 ADD: A+B
  - 1 ADDC: A+B+carry_in
  - 2 SUB: A−B
  - 3 SUBC: A−B−carry_in
  - 4 AND
  - 5 OR
  - 6 XOR
  - 7 COPY: B
  - 8 COMP: A−B, same as SUB
  - 9 BIT: A&B
  - 10 NOT: ~B
  - 11 NEG: 0−B
  - 12 LSL: A<<B[4:0]
  - 13 LSR: A>>B[4:0]
  - 14 ASR: arithmetic A>>B[4:0]
  - 15 MULU: low 32 bits of A×B
  - 16–31: result 0
- Flags on every op:
  - zero = (result == 0)
  - neg = result[31]
- Add/sub ops:
  - carry = bit 32 for add; borrow for sub/neg/comp (1 when the unsigned subtrahend including carry exceeds A)
  - over = signed overflow
- Shifts:
  - carry = last bit shifted out
  - amount 0 → carry 0
  - over 0
- All other ops: carry 0, over 0.

Test Plan:
- AGU: base 0x1000, imm 0xFFFC, immediate_mode=1 → agu_result 0x0FFC; immediate_mode=0, register_data 0x10 → 0x1010.
- Fetch: memory_access_cycle=0, pc 0x2000 → address 0x800, read 1, strobes 1111, bus_error 0.
- Byte load: agu 0x3001, width byte, data_in 0x11223344 → strobes 0100, cpu_data_in 0x22. Word store at 0x3002 with store_data 0xABCD → strobes 0011, data_out 0xABCDABCD, write 1.
- Misaligned long read at 0x3002 → bus_error 1, read 0, strobes 0000.
- ALU: ADD 0xFFFFFFFF+1 → next cycle result 0, carry 1, zero 1, over 0. ADD 0x7FFFFFFF+1 → 0x80000000, neg 1, over 1. SUB 1−2 → 0xFFFFFFFF, carry 1, neg 1.
- ALU: LSL 0x80000001 by 1 → 0x00000002, carry 1. ASR 0x80000000 by 4 → 0xF8000000. Assert reset mid-stream → result and flags 0 on the following edge.

Source files
------------

// File: rtl/agu_alu_bus_datapath.sv
// Execution/memory datapath slice: combinational AGU, registered ALU with flags,
// and a combinational big-endian bus interface with lane steering and alignment checks.
module agu_alu_bus_datapath (
    input  logic        clock,
    input  logic        reset,
    input  logic        memory_access_cycle,
    input  logic [31:0] pc,
    input  logic [31:0] base_address,
    input  logic        immediate_mode,
    input  logic [15:0] immediate,
    input  logic [31:0] register_data,
    input  logic        memory_read,
    input  logic        memory_write,
    input  logic [1:0]  memory_cycle_width,
    input  logic [31:0] store_data,
    output logic [31:0] agu_result,
    input  logic [4:0]  alu_op,
    input  logic [31:0] alu_reg2,
    input  logic [31:0] alu_reg3,
    input  logic        carry_in,
    output logic [31:0] alu_result,
    output logic        carry_out,
    output logic        zero_out,
    output logic        neg_out,
    output logic        over_out,
    output logic [29:0] address,
    input  logic [31:0] data_in,
    output logic [31:0] data_out,
    output logic [3:0]  data_strobes,
    output logic        read,
    output logic        write,
    output logic        bus_error,
    output logic [31:0] cpu_data_in
);

    localparam logic [4:0] OP_ADD  = 5'd0,  OP_ADDC = 5'd1,  OP_SUB  = 5'd2,  OP_SUBC = 5'd3;
    localparam logic [4:0] OP_AND  = 5'd4,  OP_OR   = 5'd5,  OP_XOR  = 5'd6,  OP_COPY = 5'd7;
    localparam logic [4:0] OP_COMP = 5'd8,  OP_BIT  = 5'd9,  OP_NOT  = 5'd10, OP_NEG  = 5'd11;
    localparam logic [4:0] OP_LSL  = 5'd12, OP_LSR  = 5'd13, OP_ASR  = 5'd14, OP_MULU = 5'd15;

    localparam logic [1:0] W_BYTE = 2'b00, W_WORD = 2'b01, W_LONG = 2'b10;

    logic [31:0] eff_addr;
    logic [1:0]  eff_width;
    logic        eff_read;
    logic        eff_write;
    logic        misaligned;
    logic        err;
    logic [3:0]  lane_strobes;
    logic [7:0]  byte_lane;

    always_comb begin
        agu_result = base_address + (immediate_mode ? {{16{immediate[15]}}, immediate} : register_data);
    end

    always_comb begin
        eff_addr  = memory_access_cycle ? agu_result : pc;
        eff_width = memory_access_cycle ? memory_cycle_width : W_LONG;
        eff_read  = memory_access_cycle ? memory_read : 1'b1;
        eff_write = memory_access_cycle ? memory_write : 1'b0;

        case (eff_width)
            W_BYTE:  misaligned = 1'b0;
            W_WORD:  misaligned = eff_addr[0];
            W_LONG:  misaligned = (eff_addr[1:0] != 2'b00);
            default: misaligned = 1'b1;
        endcase
        err = (eff_read | eff_write) & misaligned;

        case (eff_addr[1:0])
            2'd0:    byte_lane = data_in[31:24];
            2'd1:    byte_lane = data_in[23:16];
            2'd2:    byte_lane = data_in[15:8];
            default: byte_lane = data_in[7:0];
        endcase

        // Lane 0 (bits 31:24) holds the lowest byte address: big-endian bus.
        case (eff_width)
            W_BYTE: begin
                lane_strobes = 4'b1000 >> eff_addr[1:0];
                cpu_data_in  = {24'd0, byte_lane};
                data_out     = {4{store_data[7:0]}};
            end
            W_WORD: begin
                lane_strobes = eff_addr[1] ? 4'b0011 : 4'b1100;
                cpu_data_in  = eff_addr[1] ? {16'd0, data_in[15:0]} : {16'd0, data_in[31:16]};
                data_out     = {2{store_data[15:0]}};
            end
            W_LONG: begin
                lane_strobes = 4'b1111;
                cpu_data_in  = data_in;
                data_out     = store_data;
            end
            default: begin
                lane_strobes = 4'b0000;
                cpu_data_in  = 32'd0;
                data_out     = store_data;
            end
        endcase
        if (!memory_access_cycle) begin
            data_out = 32'd0;
        end

        address      = eff_addr[31:2];
        bus_error    = err;
        read         = eff_read & ~err;
        write        = eff_write & ~err;
        data_strobes = (err || !(eff_read || eff_write)) ? 4'b0000 : lane_strobes;
    end

    logic [32:0] wide;
    logic [31:0] result_next;
    logic        carry_next;
    logic        over_next;
    logic [4:0]  shift_amount;

    always_comb begin
        wide         = 33'd0;
        result_next  = 32'd0;
        carry_next   = 1'b0;
        over_next    = 1'b0;
        shift_amount = alu_reg3[4:0];
        case (alu_op)
            OP_ADD, OP_ADDC: begin
                wide        = {1'b0, alu_reg2} + {1'b0, alu_reg3} + {32'd0, (alu_op == OP_ADDC) & carry_in};
                result_next = wide[31:0];
                carry_next  = wide[32];
                over_next   = (alu_reg2[31] == alu_reg3[31]) && (wide[31] != alu_reg2[31]);
            end
            OP_SUB, OP_SUBC, OP_COMP: begin
                // Bit 32 of the 33-bit difference is the borrow.
                wide        = {1'b0, alu_reg2} - {1'b0, alu_reg3} - {32'd0, (alu_op == OP_SUBC) & carry_in};
                result_next = wide[31:0];
                carry_next  = wide[32];
                over_next   = (alu_reg2[31] != alu_reg3[31]) && (wide[31] != alu_reg2[31]);
            end
            OP_NEG: begin
                wide        = 33'd0 - {1'b0, alu_reg3};
                result_next = wide[31:0];
                carry_next  = wide[32];
                over_next   = alu_reg3[31] & wide[31];
            end
            OP_AND, OP_BIT: result_next = alu_reg2 & alu_reg3;
            OP_OR:          result_next = alu_reg2 | alu_reg3;
            OP_XOR:         result_next = alu_reg2 ^ alu_reg3;
            OP_COPY:        result_next = alu_reg3;
            OP_NOT:         result_next = ~alu_reg3;
            OP_LSL: begin
                // Extra bit beside the operand catches the last bit shifted out.
                wide        = {1'b0, alu_reg2} << shift_amount;
                result_next = wide[31:0];
                carry_next  = wide[32];
            end
            OP_LSR: begin
                wide        = {alu_reg2, 1'b0} >> shift_amount;
                result_next = wide[32:1];
                carry_next  = wide[0];
            end
            OP_ASR: begin
                wide        = $signed({alu_reg2, 1'b0}) >>> shift_amount;
                result_next = wide[32:1];
                carry_next  = wide[0];
            end
            OP_MULU:        result_next = alu_reg2 * alu_reg3;
            default:        result_next = 32'd0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            alu_result <= 32'd0;
            carry_out  <= 1'b0;
            zero_out   <= 1'b0;
            neg_out    <= 1'b0;
            over_out   <= 1'b0;
        end else begin
            alu_result <= result_next;
            carry_out  <= carry_next;
            zero_out   <= (result_next == 32'd0);
            neg_out    <= result_next[31];
            over_out   <= over_next;
        end
    end

endmodule

// File: tb/tb_agu_alu_bus_datapath.sv
// Scoreboard bench: stimulus pushes expectations from a behavioural model, a
// negedge monitor pops and compares combinational bus results and 1-cycle ALU results.
module tb_agu_alu_bus_datapath;

    logic        clock = 1'b0;
    logic        reset;
    logic        memory_access_cycle;
    logic [31:0] pc;
    logic [31:0] base_address;
    logic        immediate_mode;
    logic [15:0] immediate;
    logic [31:0] register_data;
    logic        memory_read;
    logic        memory_write;
    logic [1:0]  memory_cycle_width;
    logic [31:0] store_data;
    logic [31:0] agu_result;
    logic [4:0]  alu_op;
    logic [31:0] alu_reg2;
    logic [31:0] alu_reg3;
    logic        carry_in;
    logic [31:0] alu_result;
    logic        carry_out;
    logic        zero_out;
    logic        neg_out;
    logic        over_out;
    logic [29:0] address;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [3:0]  data_strobes;
    logic        read;
    logic        write;
    logic        bus_error;
    logic [31:0] cpu_data_in;

    agu_alu_bus_datapath dut (
        .clock(clock), .reset(reset),
        .memory_access_cycle(memory_access_cycle), .pc(pc),
        .base_address(base_address), .immediate_mode(immediate_mode),
        .immediate(immediate), .register_data(register_data),
        .memory_read(memory_read), .memory_write(memory_write),
        .memory_cycle_width(memory_cycle_width), .store_data(store_data),
        .agu_result(agu_result), .alu_op(alu_op), .alu_reg2(alu_reg2),
        .alu_reg3(alu_reg3), .carry_in(carry_in), .alu_result(alu_result),
        .carry_out(carry_out), .zero_out(zero_out), .neg_out(neg_out),
        .over_out(over_out), .address(address), .data_in(data_in),
        .data_out(data_out), .data_strobes(data_strobes), .read(read),
        .write(write), .bus_error(bus_error), .cpu_data_in(cpu_data_in)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          due;
        logic [31:0] agu;
        logic [29:0] addr;
        logic [3:0]  strb;
        logic [2:0]  rwe;
        logic [31:0] cpu;
        logic [31:0] dout;
    } bus_exp_t;

    typedef struct {
        int          due;
        logic [31:0] res;
        logic [3:0]  flags;  // {carry, zero, neg, over}
    } alu_exp_t;

    bus_exp_t bus_q[$];
    alu_exp_t alu_q[$];

    localparam longint SMAX = 2147483647;
    localparam longint SMIN = -SMAX - 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic alu_exp_t ref_alu(input logic [4:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input logic cin);
        alu_exp_t e;
        longint ua, ub, sa, sb, cl, full, minuend, subtr, s;
        int n;
        logic [31:0] r;
        logic c, v;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        cl = cin ? 1 : 0;
        n  = int'(b[4:0]);
        r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            5'd0, 5'd1: begin
                full = ua + ub + ((op == 5'd1) ? cl : 0);
                r = full[31:0];
                c = full > 64'hFFFF_FFFF;
                s = sa + sb + ((op == 5'd1) ? cl : 0);
                v = (s > SMAX) || (s < SMIN);
            end
            5'd2, 5'd3, 5'd8, 5'd11: begin
                minuend = (op == 5'd11) ? 0 : ua;
                subtr   = ub + ((op == 5'd3) ? cl : 0);
                full    = minuend - subtr;
                r = full[31:0];
                c = subtr > minuend;
                s = ((op == 5'd11) ? 0 : sa) - sb - ((op == 5'd3) ? cl : 0);
                v = (s > SMAX) || (s < SMIN);
            end
            5'd4, 5'd9: r = a & b;
            5'd5:  r = a | b;
            5'd6:  r = a ^ b;
            5'd7:  r = b;
            5'd10: r = ~b;
            5'd12: begin
                r = a << n;
                c = (n != 0) && ((((ua << n) >> 32) & 64'd1) != 0);
            end
            5'd13: begin
                r = a >> n;
                c = (n != 0) && (((a >> (n - 1)) & 32'd1) != 0);
            end
            5'd14: begin
                r = 32'($signed(a) >>> n);
                c = (n != 0) && (((a >> (n - 1)) & 32'd1) != 0);
            end
            5'd15: begin
                full = ua * ub;
                r = full[31:0];
            end
            default: r = 32'd0;
        endcase
        e.due   = 0;
        e.res   = r;
        e.flags = {c, (r == 32'd0), r[31], v};
        return e;
    endfunction

    function automatic bus_exp_t ref_bus();
        bus_exp_t e;
        logic [31:0] ea, cpu, dout;
        logic [3:0] st;
        logic rd, wr, err;
        int size, off;
        e.due = 0;
        e.agu = immediate_mode ? base_address + 32'($signed(immediate)) : base_address + register_data;
        if (!memory_access_cycle) begin
            ea = pc; size = 4; rd = 1'b1; wr = 1'b0;
        end else begin
            ea = e.agu; rd = memory_read; wr = memory_write;
            case (memory_cycle_width)
                2'b00:   size = 1;
                2'b01:   size = 2;
                2'b10:   size = 4;
                default: size = 0;
            endcase
        end
        err = (rd || wr) && ((size == 0) || ((int'(ea[1:0]) % size) != 0));
        st = 4'b0000;
        cpu = 32'd0;
        dout = 32'd0;
        if (size != 0) begin
            off = (int'(ea[1:0]) / size) * size;
            for (int i = 0; i < size; i++) begin
                st[3 - (off + i)] = 1'b1;
                cpu = (cpu << 8) | ((data_in >> (8 * (3 - (off + i)))) & 32'hFF);
            end
            for (int k = 0; k < 4; k++) begin
                dout = dout | (((store_data >> (8 * (size - 1 - (k % size)))) & 32'hFF) << (8 * (3 - k)));
            end
        end else begin
            dout = store_data;
        end
        if (!memory_access_cycle) dout = 32'd0;
        if (err || !(rd || wr)) st = 4'b0000;
        e.addr = ea[31:2];
        e.strb = st;
        e.rwe  = {rd && !err, wr && !err, err};
        e.cpu  = cpu;
        e.dout = dout;
        return e;
    endfunction

    task automatic issue();
        bus_exp_t be;
        alu_exp_t ae;
        be = ref_bus();
        be.due = cyc;
        bus_q.push_back(be);
        if (reset) begin
            ae.res = 32'd0;
            ae.flags = 4'b0000;
        end else begin
            ae = ref_alu(alu_op, alu_reg2, alu_reg3, carry_in);
        end
        ae.due = cyc + 1;
        alu_q.push_back(ae);
    endtask

    task automatic set_bus(input logic mac, input logic [31:0] p, input logic [31:0] base,
                           input logic imode, input logic [15:0] imm, input logic [31:0] rdata,
                           input logic rd, input logic wr, input logic [1:0] w,
                           input logic [31:0] sd, input logic [31:0] din);
        memory_access_cycle = mac; pc = p; base_address = base; immediate_mode = imode;
        immediate = imm; register_data = rdata; memory_read = rd; memory_write = wr;
        memory_cycle_width = w; store_data = sd; data_in = din;
    endtask

    task automatic set_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic cin);
        alu_op = op; alu_reg2 = a; alu_reg3 = b; carry_in = cin;
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'hFFFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every expectation whose due cycle has arrived.
    bus_exp_t mb;
    alu_exp_t ma;
    always @(negedge clock) begin
        while (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
            mb = bus_q.pop_front();
            check("agu_result", agu_result, mb.agu);
            check("address", {2'b00, address}, {2'b00, mb.addr});
            check("data_strobes", {28'd0, data_strobes}, {28'd0, mb.strb});
            check("read_write_error", {29'd0, read, write, bus_error}, {29'd0, mb.rwe});
            check("cpu_data_in", cpu_data_in, mb.cpu);
            check("data_out", data_out, mb.dout);
            $display("bus cyc=%0d agu=%h addr=%h strb=%b rwe=%b cpu=%h dout=%h",
                     cyc, agu_result, address, data_strobes, {read, write, bus_error}, cpu_data_in, data_out);
        end
        while (alu_q.size() > 0 && alu_q[0].due <= cyc) begin
            ma = alu_q.pop_front();
            check("alu_result", alu_result, ma.res);
            check("alu_flags_cznv", {28'd0, carry_out, zero_out, neg_out, over_out}, {28'd0, ma.flags});
            $display("alu cyc=%0d result=%h cznv=%b", cyc, alu_result, {carry_out, zero_out, neg_out, over_out});
        end
    end

    initial begin
        reset = 1'b1;
        set_bus(1'b0, 32'd0, 32'd0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        set_alu(5'd0, 32'd0, 32'd0, 1'b0);

        @(posedge clock); #1;
        set_alu(5'd0, 32'h1234_5678, 32'h1111_1111, 1'b1);
        issue();

        @(posedge clock); #1;
        reset = 1'b0;
        set_bus(1'b1, 32'd0, 32'h0000_1000, 1'b1, 16'hFFFC, 32'h10, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        set_alu(5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0);
        issue();

        @(posedge clock); #1;
        set_bus(1'b1, 32'd0, 32'h0000_1000, 1'b0, 16'hFFFC, 32'h10, 1'b0, 1'b0, 2'b10, 32'd0, 32'd0);
        set_alu(5'd0, 32'h7FFF_FFFF, 32'h1, 1'b0);
        issue();

        @(posedge clock); #1;
        set_bus(1'b0, 32'h0000_2000, 32'h5, 1'b1, 16'h1, 32'd0, 1'b0, 1'b1, 2'b00, 32'hDEAD_BEEF, 32'hCAFE_F00D);
        set_alu(5'd2, 32'h1, 32'h2, 1'b0);
        issue();

        @(posedge clock); #1;
        set_bus(1'b1, 32'd0, 32'h0000_3001, 1'b1, 16'h0, 32'd0, 1'b1, 1'b0, 2'b00, 32'd0, 32'h1122_3344);
        set_alu(5'd12, 32'h8000_0001, 32'h1, 1'b0);
        issue();

        @(posedge clock); #1;
        set_bus(1'b1, 32'd0, 32'h0000_3002, 1'b1, 16'h0, 32'd0, 1'b0, 1'b1, 2'b01, 32'h0000_ABCD, 32'd0);
        set_alu(5'd14, 32'h8000_0000, 32'h4, 1'b0);
        issue();

        @(posedge clock); #1;
        set_bus(1'b1, 32'd0, 32'h0000_3002, 1'b1, 16'h0, 32'd0, 1'b1, 1'b0, 2'b10, 32'd0, 32'h5566_7788);
        set_alu(5'd6, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0);
        issue();

        @(posedge clock); #1;
        reset = 1'b1;
        set_alu(5'd5, 32'h8000_0000, 32'h1, 1'b1);
        issue();

        @(posedge clock); #1;
        reset = 1'b0;
        for (int t = 0; t < 300; t++) begin
            set_bus(1'($urandom_range(0, 3) != 0), $urandom, $urandom, 1'($urandom),
                    16'($urandom), $urandom, 1'($urandom), 1'($urandom), 2'($urandom),
                    $urandom, $urandom);
            set_alu(5'($urandom_range(0, 19)), rnd_operand(), rnd_operand(), 1'($urandom));
            issue();
            @(posedge clock); #1;
        end

        repeat (3) @(posedge clock);
        #1;
        checks++;
        if (bus_q.size() != 0 || alu_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", bus_q.size() + alu_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
